// File: rtl/icetap_capture.sv
// icetap_capture: trigger-sequenced logic-analyzer capture into a circular
// RAM, read back linearised from the first pre-trigger sample onwards.
//
// Ports (all on src_clk, src_reset synchronous active-high):
//   signals_in        probe lines, sampled after a two-flop pipe (p1, p2)
//   start / abort     arm request / cancel to IDLE (abort wins)
//   store_always      store every cycle
//   trigger_always    trigger on the first armed cycle
//   pre_trigger_len   requested pre-trigger samples
//   store_mask_vec    3-bit condition code per signal, OR-combined
//   trigger_mask_vec  3-bit code per signal per stage, AND-combined
//   state             0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   stage_idx         current sequencer stage
//   start_addr        first sample of the capture
//   trigger_addr      trigger sample
//   stop_addr         last sample of the capture
//   sample_count      valid samples in the capture
//   read_req_first    read from start_addr (DONE only)
//   read_req_next     read the following sample (DONE only)
//   read_valid        read_data holds a sample (one cycle latency)
//   read_last         the sample is the final one of the capture
//   read_data         read sample
module icetap_capture #(
  parameter  int NR_SIGNALS    = 16,
  parameter  int RECORD_DEPTH  = 256,
  parameter  int NR_STAGES     = 2,
  localparam int RAM_ADDR_BITS = $clog2(RECORD_DEPTH),
  localparam int STAGE_BITS    = (NR_STAGES > 1) ? $clog2(NR_STAGES) : 1
) (
  input  logic                              src_clk,
  input  logic                              src_reset,
  input  logic [NR_SIGNALS-1:0]             signals_in,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              store_always,
  input  logic                              trigger_always,
  input  logic [RAM_ADDR_BITS-1:0]          pre_trigger_len,
  input  logic [3*NR_SIGNALS-1:0]           store_mask_vec,
  input  logic [3*NR_SIGNALS*NR_STAGES-1:0] trigger_mask_vec,
  output logic [1:0]                        state,
  output logic [STAGE_BITS-1:0]             stage_idx,
  output logic [RAM_ADDR_BITS-1:0]          start_addr,
  output logic [RAM_ADDR_BITS-1:0]          trigger_addr,
  output logic [RAM_ADDR_BITS-1:0]          stop_addr,
  output logic [RAM_ADDR_BITS:0]            sample_count,
  input  logic                              read_req_first,
  input  logic                              read_req_next,
  output logic                              read_valid,
  output logic                              read_last,
  output logic [NR_SIGNALS-1:0]             read_data
);

  localparam int AW = RAM_ADDR_BITS;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] POST  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [AW-1:0] P_MAX = AW'(RECORD_DEPTH - 1);
  localparam logic [STAGE_BITS-1:0] LAST_STAGE =
    STAGE_BITS'(NR_STAGES - 1);

  // Codes 0, 6 and 7 are don't-care.
  function automatic logic cond_care(input logic [2:0] code);
    return (code != 3'd0) && (code < 3'd6);
  endfunction

  function automatic logic cond_hit(
    input logic [2:0] code,
    input logic       cur,
    input logic       prv
  );
    logic r;
    unique case (1'b1)
      code == 3'd1: r = cur;
      code == 3'd2: r = !cur;
      code == 3'd3: r = cur && !prv;
      code == 3'd4: r = !cur && prv;
      code == 3'd5: r = cur ^ prv;
      default:      r = 1'b0;
    endcase
    return r;
  endfunction

  logic [NR_SIGNALS-1:0] p1;
  logic [NR_SIGNALS-1:0] p2;

  always_ff @(posedge src_clk) begin
    if (src_reset) begin
      p1 <= '0;
      p2 <= '0;
    end else begin
      p1 <= signals_in;
      p2 <= p1;
    end
  end

  logic                 store_qual;
  logic [NR_STAGES-1:0] stage_hit;

  always_comb begin
    store_qual = store_always;
    stage_hit  = '1;
    for (int i = 0; i < NR_SIGNALS; i++) begin
      store_qual = store_qual |
        cond_hit(store_mask_vec[3*i +: 3], p1[i], p2[i]);
    end
    for (int k = 0; k < NR_STAGES; k++) begin
      for (int i = 0; i < NR_SIGNALS; i++) begin
        stage_hit[k] = stage_hit[k] &
          (!cond_care(trigger_mask_vec[3*NR_SIGNALS*k + 3*i +: 3]) |
           cond_hit(trigger_mask_vec[3*NR_SIGNALS*k + 3*i +: 3],
                    p1[i], p2[i]));
      end
    end
  end

  logic [AW-1:0] wr_addr;
  logic [AW-1:0] pc;
  logic [AW-1:0] post_cnt;
  logic [AW-1:0] p_len;
  logic [AW-1:0] q_len;
  logic [AW-1:0] post_nxt;
  logic [AW:0]   final_cnt;
  logic          trig;
  logic          wr_en;

  assign p_len     = (pre_trigger_len > P_MAX) ? P_MAX : pre_trigger_len;
  assign q_len     = P_MAX - p_len;
  assign post_nxt  = post_cnt + AW'(1);
  assign final_cnt = (AW+1)'(pc) + (AW+1)'(q_len) + (AW+1)'(1);

  assign trig = trigger_always |
    ((stage_idx == LAST_STAGE) & stage_hit[stage_idx]);

  // The trigger sample is written regardless of the store qualifier.
  assign wr_en = !abort &
    (((state == ARMED) & (trig | store_qual)) |
     ((state == POST) & store_qual));

  always_ff @(posedge src_clk) begin
    if (src_reset) begin
      state        <= IDLE;
      stage_idx    <= '0;
      wr_addr      <= '0;
      pc           <= '0;
      post_cnt     <= '0;
      start_addr   <= '0;
      trigger_addr <= '0;
      stop_addr    <= '0;
      sample_count <= '0;
    end else if (abort) begin
      state        <= IDLE;
      sample_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= ARMED;
            wr_addr      <= '0;
            stage_idx    <= '0;
            pc           <= '0;
            sample_count <= '0;
          end
        end
        ARMED: begin
          if (trig) begin
            trigger_addr <= wr_addr;
            start_addr   <= wr_addr - pc;
            post_cnt     <= '0;
            wr_addr      <= wr_addr + AW'(1);
            if (q_len == '0) begin
              stop_addr    <= wr_addr;
              sample_count <= final_cnt;
              state        <= DONE;
            end else begin
              state <= POST;
            end
          end else if (store_qual) begin
            wr_addr <= wr_addr + AW'(1);
            if (pc < p_len) pc <= pc + AW'(1);
          end
          if (stage_hit[stage_idx] && stage_idx != LAST_STAGE)
            stage_idx <= stage_idx + STAGE_BITS'(1);
        end
        POST: begin
          if (store_qual) begin
            wr_addr  <= wr_addr + AW'(1);
            post_cnt <= post_nxt;
            if (post_nxt == q_len) begin
              stop_addr    <= wr_addr;
              sample_count <= final_cnt;
              state        <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [NR_SIGNALS-1:0] mem [RECORD_DEPTH];

  always_ff @(posedge src_clk) begin
    if (wr_en) mem[wr_addr] <= p1;
  end

  logic [AW-1:0] rd_addr;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   rd_rem;

  assign rd_nxt = rd_addr + AW'(1);

  // rd_rem counts samples still to come after the one just returned.
  always_ff @(posedge src_clk) begin
    if (src_reset) begin
      read_valid <= 1'b0;
      read_last  <= 1'b0;
      read_data  <= '0;
      rd_addr    <= '0;
      rd_rem     <= '0;
    end else begin
      read_valid <= 1'b0;
      read_last  <= 1'b0;
      if (state != DONE) begin
        rd_rem <= '0;
      end else if (read_req_first) begin
        rd_addr    <= start_addr;
        read_data  <= mem[start_addr];
        read_valid <= 1'b1;
        read_last  <= sample_count == (AW+1)'(1);
        rd_rem     <= sample_count - (AW+1)'(1);
      end else if (read_req_next && rd_rem != '0) begin
        rd_addr    <= rd_nxt;
        read_data  <= mem[rd_nxt];
        read_valid <= 1'b1;
        read_last  <= rd_rem == (AW+1)'(1);
        rd_rem     <= rd_rem - (AW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_icetap_capture.sv
// Bench for icetap_capture: configuration table, directed corner sequences
// and randomized captures against a sample-list reference model.
module tb_icetap_capture;

  localparam int NS = 4;
  localparam int RD = 16;
  localparam int NST = 2;

  logic        src_clk = 1'b0;
  logic        src_reset;
  logic [3:0]  signals_in;
  logic        start, abort, store_always, trigger_always;
  logic [3:0]  pre_trigger_len;
  logic [11:0] store_mask_vec;
  logic [23:0] trigger_mask_vec;
  logic [1:0]  state;
  logic [0:0]  stage_idx;
  logic [3:0]  start_addr, trigger_addr, stop_addr;
  logic [4:0]  sample_count;
  logic        read_req_first, read_req_next;
  logic        read_valid, read_last;
  logic [3:0]  read_data;

  always #5 src_clk = ~src_clk;

  icetap_capture #(
    .NR_SIGNALS(NS), .RECORD_DEPTH(RD), .NR_STAGES(NST)
  ) dut (
    .src_clk(src_clk), .src_reset(src_reset),
    .signals_in(signals_in), .start(start), .abort(abort),
    .store_always(store_always), .trigger_always(trigger_always),
    .pre_trigger_len(pre_trigger_len),
    .store_mask_vec(store_mask_vec),
    .trigger_mask_vec(trigger_mask_vec),
    .state(state), .stage_idx(stage_idx),
    .start_addr(start_addr), .trigger_addr(trigger_addr),
    .stop_addr(stop_addr), .sample_count(sample_count),
    .read_req_first(read_req_first), .read_req_next(read_req_next),
    .read_valid(read_valid), .read_last(read_last),
    .read_data(read_data)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: keeps the lists of stored samples and derives
  // addresses and the readback order from them.
  int m_state, m_stage, m_nst, m_k, m_q, m_pos;
  int m_trig, m_start, m_stop, m_cnt;
  logic [3:0] m_p1, m_p2, m_tsample;
  logic [3:0] pre_q[$], post_q[$], seq[$];
  bit exp_valid, exp_last;
  logic [3:0] exp_data;

  function automatic bit hit(int code, bit c, bit p);
    case (code)
      1: return c;
      2: return !c;
      3: return c && !p;
      4: return !c && p;
      5: return c != p;
      default: return 0;
    endcase
  endfunction

  function automatic bit qual();
    if (store_always) return 1;
    for (int i = 0; i < NS; i++)
      if (hit(int'(store_mask_vec[3*i +: 3]), m_p1[i], m_p2[i]))
        return 1;
    return 0;
  endfunction

  function automatic bit smatch(int k);
    for (int i = 0; i < NS; i++) begin
      int code = int'(trigger_mask_vec[12*k + 3*i +: 3]);
      if (code >= 1 && code <= 5 && !hit(code, m_p1[i], m_p2[i]))
        return 0;
    end
    return 1;
  endfunction

  task automatic finish_capture();
    m_stop = (m_nst - 1) % RD;
    m_cnt = m_k + 1 + m_q;
    seq.delete();
    for (int i = pre_q.size() - m_k; i < pre_q.size(); i++)
      seq.push_back(pre_q[i]);
    seq.push_back(m_tsample);
    foreach (post_q[i]) seq.push_back(post_q[i]);
    m_pos = seq.size();
    m_state = 3;
  endtask

  task automatic model_step();
    exp_valid = 0;
    exp_last = 0;
    if (src_reset) begin
      m_state = 0; m_stage = 0; m_trig = 0; m_start = 0;
      m_stop = 0; m_cnt = 0; m_pos = 0; m_p1 = 0; m_p2 = 0;
      seq.delete();
      return;
    end
    if (m_state == 3) begin
      if (read_req_first) begin
        exp_valid = 1; exp_data = seq[0];
        exp_last = seq.size() == 1; m_pos = 1;
      end else if (read_req_next && m_pos < seq.size()) begin
        exp_valid = 1; exp_data = seq[m_pos];
        exp_last = m_pos == seq.size() - 1; m_pos++;
      end
    end
    if (abort) begin
      m_state = 0; m_cnt = 0;
    end else begin
      case (m_state)
        0, 3: if (start) begin
          m_state = 1; m_stage = 0; m_nst = 0; m_cnt = 0;
          pre_q.delete(); post_q.delete();
        end
        1: begin
          int p = int'(pre_trigger_len);
          bit trg = trigger_always || (m_stage == NST-1 && smatch(NST-1));
          bit adv = m_stage < NST-1 && smatch(m_stage);
          if (trg) begin
            m_k = (pre_q.size() < p) ? pre_q.size() : p;
            m_trig = m_nst % RD;
            m_start = (m_nst - m_k) % RD;
            m_tsample = m_p1;
            m_nst++;
            m_q = RD - 1 - p;
            if (m_q == 0) finish_capture();
            else m_state = 2;
          end else if (qual()) begin
            pre_q.push_back(m_p1);
            m_nst++;
          end
          if (adv) m_stage++;
        end
        2: if (qual()) begin
          post_q.push_back(m_p1);
          m_nst++;
          if (post_q.size() == m_q) finish_capture();
        end
        default: ;
      endcase
    end
    m_p2 = m_p1;
    m_p1 = signals_in;
  endtask

  task automatic cyc(input logic [3:0] sig);
    signals_in = sig;
    model_step();
    @(posedge src_clk);
    #1;
    chk("state", state, m_state);
    chk("stage_idx", stage_idx, m_stage);
    chk("read_valid", read_valid, exp_valid);
    chk("read_last", read_last, exp_last);
    if (exp_valid) chk("read_data", read_data, exp_data);
    start = 0; abort = 0; src_reset = 0;
    read_req_first = 0; read_req_next = 0;
  endtask

  task automatic chk_addrs();
    chk("trigger_addr", trigger_addr, m_trig);
    chk("start_addr", start_addr, m_start);
    chk("stop_addr", stop_addr, m_stop);
    chk("sample_count", sample_count, m_cnt);
  endtask

  task automatic run_until_done(input int bound, output int n);
    n = 0;
    while (state != 2'd3 && n < bound) begin
      cyc(4'($urandom));
      n++;
    end
    chk("done_reached", state, 3);
  endtask

  task automatic read_all();
    int nv;
    read_req_first = 1;
    cyc(4'($urandom));
    nv = int'(read_valid);
    for (int i = 0; i < m_cnt; i++) begin
      if ($urandom_range(0, 3) == 0) cyc(4'($urandom));
      read_req_next = 1;
      cyc(4'($urandom));
      nv += int'(read_valid);
    end
    chk("read_count", nv, m_cnt);
  endtask

  task automatic normal_trig(input int p, input int tj, input int e_trig,
                             input int e_start, input int e_stop,
                             input int e_cnt);
    int n;
    store_always = 1; trigger_always = 0;
    pre_trigger_len = 4'(p);
    store_mask_vec = '0;
    trigger_mask_vec = 24'h003000;
    start = 1;
    cyc(4'd0);
    for (int j = 0; j < tj - 1; j++) cyc(4'((j * 2) % 16));
    cyc(4'b0001);
    run_until_done(40, n);
    chk("norm_trigger_addr", trigger_addr, e_trig);
    chk("norm_start_addr", start_addr, e_start);
    chk("norm_stop_addr", stop_addr, e_stop);
    chk("norm_sample_count", sample_count, e_cnt);
    chk_addrs();
    read_all();
  endtask

  function automatic logic [2:0] rcode();
    return ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
  endfunction

  typedef struct {
    bit sa; bit ta; int p;
    int ticks; int trig; int st; int stop; int cnt;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n;
    tbl[0] = '{1, 1, 0, 17, 0, 0, 15, 16};
    tbl[1] = '{1, 1, 4, 13, 0, 0, 11, 12};
    tbl[2] = '{1, 1, 7, 10, 0, 0, 8, 9};
    tbl[3] = '{1, 1, 15, 2, 0, 0, 0, 1};
    tbl[4] = '{1, 0, 4, 14, 1, 0, 12, 13};
    tbl[5] = '{1, 0, 0, 18, 1, 1, 0, 16};
    tbl[6] = '{1, 0, 15, 3, 1, 0, 1, 2};

    signals_in = 0; start = 0; abort = 0;
    store_always = 0; trigger_always = 0; pre_trigger_len = 0;
    store_mask_vec = 0; trigger_mask_vec = 0;
    read_req_first = 0; read_req_next = 0;
    src_reset = 1;
    cyc(4'hF);
    chk("rst_state", state, 0);
    chk("rst_stage", stage_idx, 0);
    chk("rst_start", start_addr, 0);
    chk("rst_trig", trigger_addr, 0);
    chk("rst_stop", stop_addr, 0);
    chk("rst_count", sample_count, 0);
    chk("rst_rvalid", read_valid, 0);
    chk("rst_rlast", read_last, 0);
    chk("rst_rdata", read_data, 0);
    cyc(4'd0);

    foreach (tbl[r]) begin
      store_always = tbl[r].sa;
      trigger_always = tbl[r].ta;
      pre_trigger_len = 4'(tbl[r].p);
      store_mask_vec = '0;
      trigger_mask_vec = '0;
      start = 1;
      n = 0;
      do begin
        cyc(4'($urandom));
        n++;
      end while (state != 2'd3 && n < 40);
      chk("tbl_ticks", n, tbl[r].ticks);
      chk("tbl_trigger_addr", trigger_addr, tbl[r].trig);
      chk("tbl_start_addr", start_addr, tbl[r].st);
      chk("tbl_stop_addr", stop_addr, tbl[r].stop);
      chk("tbl_sample_count", sample_count, tbl[r].cnt);
    end
    trigger_always = 0;

    normal_trig(4, 10, 10, 6, 5, 16);
    normal_trig(15, 20, 4, 5, 4, 16);

    // Store qualifier: sig1 rising only; trigger on sig0 high.
    store_always = 0; trigger_always = 0; pre_trigger_len = 4'd15;
    store_mask_vec = 12'h018;
    trigger_mask_vec = 24'h001000;
    start = 1;
    cyc(4'd0);
    for (int j = 0; j < 24; j++)
      cyc(4'(((j % 4) << 2) | (((j / 4) % 2) << 1)));
    cyc(4'b0001);
    run_until_done(10, n);
    chk("qual_sample_count", sample_count, 4);
    chk("qual_trigger_addr", trigger_addr, 3);
    chk("qual_start_addr", start_addr, 0);
    chk_addrs();
    read_all();

    // Sequencing: stage0 sig2 high, stage1 sig3 high.
    store_always = 1; pre_trigger_len = 4'd8;
    store_mask_vec = '0;
    trigger_mask_vec = 24'h200040;
    start = 1;
    cyc(4'd0);
    for (int j = 0; j < 8; j++) cyc((j == 4) ? 4'b1000 : 4'd0);
    chk("seq_stage_hold", stage_idx, 0);
    chk("seq_no_trigger", state, 1);
    cyc(4'b0100);
    cyc(4'd0);
    chk("seq_stage_adv", stage_idx, 1);
    for (int j = 10; j < 14; j++) cyc((j == 12) ? 4'b1000 : 4'd0);
    chk("seq_post", state, 2);
    chk("seq_trigger_addr", trigger_addr, 13);
    run_until_done(40, n);
    chk_addrs();
    read_all();

    // Abort in POST.
    store_always = 1; trigger_always = 1; pre_trigger_len = 4'd4;
    trigger_mask_vec = '0;
    start = 1;
    cyc(4'd0);
    cyc(4'd1);
    cyc(4'd2);
    chk("abort_in_post", state, 2);
    abort = 1;
    start = 1;
    cyc(4'd3);
    chk("abort_state", state, 0);
    chk("abort_count", sample_count, 0);
    read_req_first = 1;
    cyc(4'd0);
    chk("abort_no_read", read_valid, 0);
    read_req_next = 1;
    cyc(4'd0);
    chk("abort_no_read_next", read_valid, 0);

    // Reset in the middle of a readout.
    pre_trigger_len = 4'd15;
    start = 1;
    cyc(4'd5);
    run_until_done(10, n);
    read_req_first = 1;
    cyc(4'd0);
    read_req_next = 1;
    cyc(4'd0);
    src_reset = 1;
    read_req_next = 1;
    cyc(4'd0);
    chk("mrst_state", state, 0);
    chk("mrst_stage", stage_idx, 0);
    chk("mrst_start", start_addr, 0);
    chk("mrst_trig", trigger_addr, 0);
    chk("mrst_stop", stop_addr, 0);
    chk("mrst_count", sample_count, 0);
    chk("mrst_rvalid", read_valid, 0);
    chk("mrst_rlast", read_last, 0);
    chk("mrst_rdata", read_data, 0);
    trigger_always = 0;

    // Randomized captures.
    for (int r = 0; r < 25; r++) begin
      store_always = 1'($urandom);
      trigger_always = 0;
      pre_trigger_len = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) store_mask_vec[3*i +: 3] = rcode();
      for (int i = 0; i < 8; i++) trigger_mask_vec[3*i +: 3] = rcode();
      start = 1;
      cyc(4'($urandom));
      n = 0;
      while (state != 2'd3 && n < 400) begin
        if (n == 150) trigger_always = 1;
        if (n == 300) store_always = 1;
        cyc(4'($urandom));
        n++;
      end
      chk("rand_done", state, 3);
      chk_addrs();
      trigger_always = 0;
      read_all();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
